// File: rtl/display_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : display_sched_if
// Purpose  : Bundles the control inputs and display-select outputs of the
//            display scheduler.
// Signals  : button, dice_period[3:0], tl_period[3:0], force_dice, force_tl
//            (driven by master); sel, blank, dice_btn, tl_en (driven by slave)
// Modports : master - controller side; slave - display_sched side
// Revision : 1.0 - initial release
// ============================================================================
interface display_sched_if;
  logic       button;
  logic [3:0] dice_period;
  logic [3:0] tl_period;
  logic       force_dice;
  logic       force_tl;
  logic       sel;
  logic       blank;
  logic       dice_btn;
  logic       tl_en;

  modport master (
    output button, dice_period, tl_period, force_dice, force_tl,
    input  sel, blank, dice_btn, tl_en
  );

  modport slave (
    input  button, dice_period, tl_period, force_dice, force_tl,
    output sel, blank, dice_btn, tl_en
  );
endinterface
`default_nettype wire

// File: rtl/display_sched.sv
`default_nettype none
// ============================================================================
// Module   : display_sched
// Purpose  : Time-multiplexes one display between a dice roller and a
//            traffic-light controller. Each slot dwells for period+1 cycles,
//            separated by one blanked guard cycle. Forces can hold or
//            pre-empt a slot; a pressed dice button freezes the dice slot.
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            bus.slave  - button, periods and forces in;
//                         sel, blank, dice_btn, tl_en out
// Revision : 1.0 - initial release
// ============================================================================
module display_sched (
  input  logic            clk,
  input  logic            rst,
  display_sched_if.slave  bus
);

  localparam logic [1:0] S_DICE   = 2'd0;
  localparam logic [1:0] S_G2TL   = 2'd1;
  localparam logic [1:0] S_TL     = 2'd2;
  localparam logic [1:0] S_G2DICE = 2'd3;

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_dice_btn;
  logic [1:0] w_next_state;
  logic [3:0] w_next_cnt;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      // Guards ignore every input and reload the dwell counter for the
      // slot they lead into.
      S_G2TL: begin
        w_next_state = S_TL;
        w_next_cnt   = bus.tl_period;
      end
      S_G2DICE: begin
        w_next_state = S_DICE;
        w_next_cnt   = bus.dice_period;
      end
      S_DICE: begin
        // A pressed button always wins so a roll in progress is never cut.
        if (bus.button || bus.force_dice) begin
          w_next_state = S_DICE;
        end else if (bus.force_tl || (r_cnt == 4'd0)) begin
          w_next_state = S_G2TL;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: begin  // S_TL
        if (bus.force_tl) begin
          w_next_state = S_TL;
        end else if (bus.force_dice || (r_cnt == 4'd0)) begin
          w_next_state = S_G2DICE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_DICE;
      r_cnt      <= bus.dice_period;
      r_dice_btn <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_dice_btn <= bus.button && (r_state == S_DICE);
    end
  end

  assign bus.sel      = (r_state == S_G2TL) || (r_state == S_TL);
  assign bus.blank    = (r_state == S_G2TL) || (r_state == S_G2DICE);
  assign bus.tl_en    = (r_state == S_TL);
  assign bus.dice_btn = r_dice_btn;

endmodule
`default_nettype wire
